// File: rtl/fa_pipe_nbit_pkg.sv
// fa_pipe_nbit_pkg: shared mode encodings and stage-count helper for the pipelined adder.
package fa_pipe_nbit_pkg;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int stages(input int width, input int seg);
        return width / seg;
    endfunction
endpackage

// File: rtl/fa_seg_stage.sv
// fa_seg_stage: one SEG-bit carry segment with its enable-gated sum/carry/valid register.
module fa_seg_stage
    import fa_pipe_nbit_pkg::*;
#(
    parameter int SEG = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_en,
    input  logic           i_valid,
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_c,
    output logic           o_valid,
    output logic [SEG-1:0] o_sum,
    output logic           o_c,
    output logic           o_ovf
);
    logic [SEG:0] w_sum;
    logic         w_cm;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_c};
    // carry into the slice MSB recovered from its sum bit, so SEG = 1 needs no special case
    assign w_cm  = i_a[SEG-1] ^ i_b[SEG-1] ^ w_sum[SEG-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_c     <= 1'b0;
            o_ovf   <= 1'b0;
        end else if (i_en) begin
            o_valid <= i_valid;
            o_sum   <= w_sum[SEG-1:0];
            o_c     <= w_sum[SEG];
            o_ovf   <= w_cm ^ w_sum[SEG];
        end
    end
endmodule

// File: rtl/fa_pipe_nbit.sv
// fa_pipe_nbit: N-bit add/subtract pipelined in SEG-bit carry segments,
// valid/ready handshake with a single global stall enable.
module fa_pipe_nbit
    import fa_pipe_nbit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);
    localparam int STAGES = stages(WIDTH, SEG);

    logic              w_en;
    logic [WIDTH-1:0]  w_a   [STAGES];
    logic [WIDTH-1:0]  w_b   [STAGES];
    logic [WIDTH-1:0]  w_sl  [STAGES];
    logic [SEG-1:0]    w_sum [STAGES];
    logic [STAGES:0]   w_v;
    logic [STAGES:0]   w_c;
    logic [STAGES-1:0] w_ovf;

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;
    assign w_v[0]   = in_valid;
    assign w_a[0]   = a;
    assign w_b[0]   = (sub == OP_SUB) ? ~b : b;
    assign w_c[0]   = (sub == OP_SUB) ? 1'b1 : ci;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        fa_seg_stage #(.SEG(SEG)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_en),
            .i_valid (w_v[k]),
            .i_a     (w_a[k][SEG-1:0]),
            .i_b     (w_b[k][SEG-1:0]),
            .i_c     (w_c[k]),
            .o_valid (w_v[k+1]),
            .o_sum   (w_sum[k]),
            .o_c     (w_c[k+1]),
            .o_ovf   (w_ovf[k])
        );
        // w_sl[k]: all sum slices finished so far for the beat leaving stage k
        if (k == 0) begin : g_lo
            assign w_sl[0] = WIDTH'(w_sum[0]);
        end else begin : g_skew_s
            logic [WIDTH-1:0] r_s;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_s <= '0;
                else if (w_en)
                    r_s <= w_sl[k-1];
            end
            assign w_sl[k] = r_s | (WIDTH'(w_sum[k]) << (k * SEG));
        end
        // operands shift down so the next stage always reads its slice at bit 0
        if (k < STAGES - 1) begin : g_skew_op
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_a[k] >> SEG;
                    r_b <= w_b[k] >> SEG;
                end
            end
            assign w_a[k+1] = r_a;
            assign w_b[k+1] = r_b;
        end
    end

    assign out_valid = w_v[STAGES];
    assign s         = w_sl[STAGES-1];
    assign co        = w_c[STAGES];
    assign ovf       = w_ovf[STAGES-1];
    assign zero      = out_valid && (s == '0);
endmodule

// File: tb/tb_fa_pipe_nbit.sv
// tb_fa_pipe_nbit: directed and random stimulus against an arithmetic reference model with a result scoreboard.
module tb_fa_pipe_nbit;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf, zero;
    logic [15:0] a, b, s;

    int          checks = 0, passed = 0, failed = 0, cyc = 0, n_out = 0, acc_cyc = 0, last_cyc = 0, base;
    logic [18:0] q[$];
    int          out_cyc[$];
    logic [18:0] last_out, sn_out, hold;
    logic        sn_ir, sn_ov;

    fa_pipe_nbit #(.WIDTH(16), .SEG(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [18:0] model(logic [15:0] ma, logic [15:0] mb, logic mci, logic msub);
        int          sa, sb, r, u;
        logic [15:0] rs;
        logic        mco, mov;
        sa  = $signed(ma);
        sb  = $signed(mb);
        u   = msub ? int'(ma) - int'(mb) : int'(ma) + int'(mb) + int'(mci);
        rs  = u[15:0];
        mco = msub ? (ma >= mb) : (u > 65535);
        r   = msub ? sa - sb : sa + sb + int'(mci);
        mov = (r > 32767) || (r < -32768);
        return {rs, mco, mov, rs == 16'h0};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sn_ir  = in_ready;
        sn_ov  = out_valid;
        sn_out = {s, co, ovf, zero};
        if (out_valid && out_ready) begin
            n_out++;
            last_out = sn_out;
            last_cyc = cyc;
            out_cyc.push_back(cyc);
            chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) chk("beat", 32'(sn_out), 32'(q.pop_front()));
        end
        if (in_valid && in_ready) begin
            q.push_back(model(a, b, ci, sub));
            acc_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(logic [15:0] sa_, logic [15:0] sb_, logic sci, logic ssub);
        a = sa_; b = sb_; ci = sci; sub = ssub; in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (sn_ir) break;
        end
        chk("accepted", 32'(sn_ir), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && q.size() != 0; k++) tick();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_s", 32'(s), 0);
        chk("rst_flags", 32'({co, ovf, zero}), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        tick();

        base = n_out;
        send(16'h1234, 16'h0FCD, 1'b1, 1'b0);
        drain();
        tick(); tick(); tick();
        chk("first_result", 32'(last_out), 32'({16'h2202, 3'b000}));
        chk("first_latency", 32'(last_cyc - acc_cyc), 32'd4);
        chk("first_once", 32'(n_out - base), 32'd1);

        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        drain();
        chk("full_ripple", 32'(last_out), 32'({16'h0000, 3'b101}));
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        drain();
        chk("ovf_add", 32'(last_out), 32'({16'h8000, 3'b010}));
        send(16'h8000, 16'h0001, 1'b1, 1'b1);
        drain();
        chk("ovf_sub", 32'(last_out), 32'({16'h7FFF, 3'b110}));

        base = n_out;
        for (int i = 0; i < 8; i++) send(16'(i * 16'h1111), 16'h0101, 1'b0, i[0]);
        drain();
        chk("stream_count", 32'(n_out - base), 32'd8);
        chk("stream_contig", 32'(out_cyc[out_cyc.size()-1] - out_cyc[out_cyc.size()-8]), 32'd7);

        base = n_out;
        for (int i = 0; i < 4; i++) send(16'(16'h0F0F + i * 16'h2345), 16'(16'h1357 * (i + 1)), i[1], i[0]);
        chk("bp_full", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        a = 16'hA5A5; b = 16'h5A5A; ci = 1'b1; sub = 1'b0; in_valid = 1'b1;
        hold = {s, co, ovf, zero};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", 32'(sn_ir), 32'd0);
            chk("bp_hold", 32'({sn_ov, sn_out}), 32'({1'b1, hold}));
        end
        out_ready = 1'b1;
        send(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
        send(16'h0001, 16'h0002, 1'b0, 1'b1);
        drain();
        chk("bp_count", 32'(n_out - base), 32'd6);

        for (int i = 0; i < 4; i++) send(16'(16'h1000 * (i + 1)), 16'h0333, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_data", 32'({s, co, ovf, zero}), 0);
        q.delete();
        tick(); tick();
        rst_n = 1'b1;
        base = n_out;
        for (int i = 0; i < 8; i++) tick();
        chk("no_stale", 32'(n_out - base), 32'd0);
        send(16'h4321, 16'h1234, 1'b0, 1'b1);
        drain();
        chk("post_rst_result", 32'(last_out), 32'({16'h30ED, 3'b100}));
        chk("post_rst_latency", 32'(last_cyc - acc_cyc), 32'd4);

        for (int i = 0; i < 80; i++) begin
            in_valid  = ($urandom % 4) != 0;
            a         = 16'($urandom);
            sub       = 1'($urandom);
            b         = (($urandom % 5) == 0) ? a : 16'($urandom);
            ci        = 1'($urandom);
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fa_pipe_nbit.md
Name: fa_pipe_nbit

Overview:
- Parametrised successor to the fixed 4-bit ripple adder: an N-bit add/subtract unit, pipelined in SEG-bit carry-chain segments, one pipeline register per segment.
- Carries a valid/ready handshake with full backpressure.
- Reports carry, signed overflow and zero flags.
- Used wherever wide datapath arithmetic has to meet timing that a single N-bit ripple chain cannot.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
SEG, 4, bits added per pipeline stage; STAGES = WIDTH/SEG, STAGES >= 1.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand beat present.
in_ready  output  1  block accepts a beat this cycle.
a  input  WIDTH  operand A, unsigned/two's complement.
b  input  WIDTH  operand B.
ci  input  1  carry-in; used in add mode only.
sub  input  1  0 = add (a+b+ci), 1 = subtract (a-b; ci ignored).
out_valid  output  1  result beat present.
out_ready  input  1  downstream accepts result.
s  output  WIDTH  result modulo 2^WIDTH.
co  output  1  carry out of MSB. In subtract mode, 1 = no borrow (a >= b unsigned).
ovf  output  1  signed overflow.
zero  output  1  s == 0.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, s, co, ovf and zero go to 0 immediately; out_valid = 0. In-flight beats are discarded with no partial output. Deassertion takes effect from the next rising edge.
- Transfer rules:
  - Input transfer on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
- Global stall enable: en = !out_valid || out_ready; in_ready = en.
  - When en = 0, every stage register holds, including bubbles.
  - No stage compresses bubbles, so throughput is 1 beat/cycle when out_ready stays high.
- Latency: a beat accepted at edge t appears on out_valid after edge t+STAGES-1, i.e. STAGES cycles of register delay, provided there is no stall. STAGES = 1 degenerates to a single registered adder.
- Operand conditioning at entry: bb = sub ? ~b : b; c0 = sub ? 1 : ci.
- Staircase datapath:
  - Stage k (0..STAGES-1) adds a[k*SEG +: SEG] + bb[k*SEG +: SEG] + carry from stage k-1, or c0 for k = 0.
  - It registers the SEG-bit sum slice and the carry.
  - Unconsumed upper operand slices and completed lower sum slices travel in skew registers alongside the beat, so each beat stays coherent.
- Flags, computed in the final stage from the same beat:
  - co = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (s == 0).
- Bubbles (valid = 0) propagate; their data registers may update but are don't-care. The output data ports are only meaningful while out_valid = 1.
- Output holds stable (s, co, ovf, zero unchanged) while out_valid && !out_ready.
- Mode and ci are sampled with the beat. Changing sub on consecutive beats is legal and each beat uses its own mode.
- Simultaneous input and output transfer while full: legal. The pipeline advances, the new beat enters, and the old result leaves the same edge.

Decomposition:
- Shared package: localparam OP_ADD = 1'b0, OP_SUB = 1'b1; function/constant for STAGES = WIDTH/SEG.
- One natural sub-module: fa_seg_stage. It holds the SEG-bit slice adder, the enable-gated register for sum slice and carry, and the valid bit. Instantiate it STAGES times via generate, mirroring the slice-by-slice chaining of full-adder instances.
- Skew registers live in the top module.

Test Plan (WIDTH=16, SEG=4, STAGES=4):
- Reset, then a=16'h1234, b=16'h0FCD, ci=1, sub=0, out_ready=1 -> after 4 cycles out_valid=1, s=16'h2202, co=0, ovf=0, zero=0, for exactly one cycle.
- Full carry ripple: a=16'hFFFF, b=16'h0000, ci=1, add -> s=16'h0000, co=1, zero=1, ovf=0 (carry crosses all 4 stages).
- Signed overflow:
  - a=16'h7FFF, b=16'h0001, add -> s=16'h8000, ovf=1, co=0.
  - a=16'h8000, b=16'h0001, sub -> s=16'h7FFF, ovf=1, co=1.
- Back-to-back stream of 8 beats, alternating add/sub (a=i*16'h1111, b=16'h0101, ci=0), with out_ready=1 -> 8 consecutive out_valid cycles, results match a reference model in order.
- Backpressure: stream 6 beats and hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, the output holds stable, no beat is lost or duplicated, and order is preserved.
- Reset mid-operation: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately with flags at 0. After release no stale beat emerges; a new beat returns after 4 cycles.
